// File: rtl/cnn_inst_pkg.sv
// Shared constants and state type for the CNN instruction loader.
package cnn_inst_pkg;

  localparam int INST_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_INST = 4;

  localparam logic [WORD_W-1:0] CMD_CLEAR          = 32'h0000_0001;
  localparam logic [WORD_W-1:0] CMD_START          = 32'h0000_0002;
  localparam logic [15:0]       DEFAULT_LOAD_MAGIC = 16'hA5A5;

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

endpackage

// File: rtl/cnn_inst_word_packer.sv
// Gathers four 32-bit words into one 128-bit instruction, first word in the LSBs.
module cnn_inst_word_packer
  import cnn_inst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              word_en,
  input  logic [WORD_W-1:0] word,
  output logic              done,
  output logic [INST_W-1:0] inst
);

  logic [1:0]               word_cnt;
  logic [INST_W-WORD_W-1:0] shift_reg;

  // Words enter at the top and move down, so after three words the oldest sits at [31:0].
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      word_cnt  <= 2'd0;
      shift_reg <= '0;
    end else if (word_en) begin
      word_cnt  <= word_cnt + 2'd1;
      shift_reg <= {word, shift_reg[INST_W-WORD_W-1:WORD_W]};
    end
  end

  assign done = word_en && !flush && (word_cnt == 2'(WORDS_PER_INST - 1));
  assign inst = {word, shift_reg};

endmodule

// File: rtl/cnn_inst_loader.sv
// Decodes the host word stream, writes assembled instructions to the instruction RAM
// and hands a start pulse to the executor.
module cnn_inst_loader
  import cnn_inst_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          TIMEOUT    = 65535,
  parameter logic [15:0] LOAD_MAGIC = DEFAULT_LOAD_MAGIC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] inst_part,
  input  logic              inst_part_en,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [INST_W-1:0] ram_data,
  input  logic              cnn_inst_ready,
  output logic              cnn_inst_start,
  output logic [ADDR_W:0]   inst_count,
  output logic              busy,
  output logic              error
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              error_q, error_d;
  logic              pending_q, pending_d;
  logic              wren_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [INST_W-1:0] data_d;
  logic              flush;
  logic              packer_done;
  logic [INST_W-1:0] packer_inst;
  logic              start_fire;

  cnn_inst_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .word_en (inst_part_en && (state_q == LOAD)),
    .word    (inst_part),
    .done    (packer_done),
    .inst    (packer_inst)
  );

  assign start_fire = pending_q && cnn_inst_ready && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timeout_d   = timeout_q;
    count_d     = count_q;
    error_d     = error_q;
    pending_d   = pending_q;
    wren_d      = 1'b0;
    waddr_d     = ram_wraddr;
    data_d      = ram_data;
    flush       = 1'b0;

    if (start_fire) pending_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (inst_part_en) begin
          if (inst_part == CMD_CLEAR) begin
            count_d   = '0;
            error_d   = 1'b0;
            pending_d = 1'b0;
          end else if (inst_part == CMD_START) begin
            // A START arriving while one is still pending merges into that pulse.
            if (!pending_q) pending_d = 1'b1;
          end else if (inst_part[31:16] == LOAD_MAGIC) begin
            if (inst_part[15:0] == 16'd0) begin
              error_d = 1'b1;
            end else begin
              remaining_d = inst_part[15:0];
              timeout_d   = '0;
              state_d     = LOAD;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (inst_part_en) begin
          timeout_d = '0;
          if (packer_done) begin
            // A full RAM keeps consuming the frame but stores nothing more.
            if (count_q[ADDR_W]) begin
              error_d = 1'b1;
            end else begin
              wren_d  = 1'b1;
              waddr_d = count_q[ADDR_W-1:0];
              data_d  = packer_inst;
              count_d = count_q + 1'b1;
            end
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_d = IDLE;
          end
        end else if (timeout_q == TO_W'(TIMEOUT - 1)) begin
          flush     = 1'b1;
          error_d   = 1'b1;
          timeout_d = '0;
          state_d   = IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      timeout_q   <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      pending_q   <= 1'b0;
      ram_wren    <= 1'b0;
      ram_wraddr  <= '0;
      ram_data    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
      error_q     <= error_d;
      pending_q   <= pending_d;
      ram_wren    <= wren_d;
      ram_wraddr  <= waddr_d;
      ram_data    <= data_d;
    end
  end

  assign cnn_inst_start = start_fire;
  assign busy           = (state_q == LOAD) || pending_q;
  assign inst_count     = count_q;
  assign error          = error_q;

endmodule

// File: tb/tb_cnn_inst_loader.sv
// Scoreboard bench for cnn_inst_loader: a frame-level model predicts RAM writes and
// start pulses, and a negedge monitor matches them against what the loader emits.
module tb_cnn_inst_loader;

  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       inst_part;
  logic              inst_part_en;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [127:0]      ram_data;
  logic              cnn_inst_ready;
  logic              cnn_inst_start;
  logic [ADDR_W:0]   inst_count;
  logic              busy;
  logic              error;

  cnn_inst_loader #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT    (TIMEOUT),
    .LOAD_MAGIC (16'hA5A5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_part      (inst_part),
    .inst_part_en   (inst_part_en),
    .ram_wren       (ram_wren),
    .ram_wraddr     (ram_wraddr),
    .ram_data       (ram_data),
    .cnn_inst_ready (cnn_inst_ready),
    .cnn_inst_start (cnn_inst_start),
    .inst_count     (inst_count),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [127:0]      data;
  } wr_t;

  wr_t         exp_wr[$];
  int          exp_start[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses_seen = 0;
  int          pulses_exp = 0;

  bit          m_load, m_pending, m_error;
  int          m_count, m_rem, m_silent;
  logic [31:0] m_part[$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame-level model of one clock cycle; model state mirrors what the loader holds during that cycle.
  task automatic modelStep(input logic en, input logic [31:0] w, input logic rdy);
    bit pb;
    wr_t e;
    pb = m_pending;
    if (m_pending && rdy && !m_load) begin
      exp_start.push_back(cyc);
      pulses_exp++;
      m_pending = 0;
    end
    if (!m_load) begin
      if (en) begin
        if (w == 32'h1) begin
          m_count = 0; m_error = 0; m_pending = 0;
        end else if (w == 32'h2) begin
          if (!pb) m_pending = 1;
        end else if (w[31:16] == 16'hA5A5) begin
          if (w[15:0] == 16'd0) m_error = 1;
          else begin
            m_load = 1; m_rem = int'(w[15:0]); m_silent = 0; m_part.delete();
          end
        end else begin
          m_error = 1;
        end
      end
    end else if (en) begin
      m_silent = 0;
      m_part.push_back(w);
      if (m_part.size() == 4) begin
        if (m_count == (1 << ADDR_W)) m_error = 1;
        else begin
          e.cyc  = cyc + 1;
          e.addr = ADDR_W'(m_count);
          e.data = {m_part[3], m_part[2], m_part[1], m_part[0]};
          exp_wr.push_back(e);
          m_count++;
        end
        m_part.delete();
        m_rem--;
        if (m_rem == 0) m_load = 0;
      end
    end else begin
      m_silent++;
      if (m_silent == TIMEOUT) begin
        m_load = 0; m_error = 1; m_silent = 0; m_part.delete();
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] w, input logic rdy);
    @(posedge clk);
    #1;
    inst_part_en   = en;
    inst_part      = w;
    cnn_inst_ready = rdy;
    modelStep(en, w, rdy);
  endtask

  task automatic idleAndCheck(input logic rdy, input string tag);
    @(posedge clk);
    #1;
    inst_part_en   = 1'b0;
    inst_part      = '0;
    cnn_inst_ready = rdy;
    checkOutput({tag, "_count"}, 128'(inst_count), 128'(m_count));
    checkOutput({tag, "_error"}, 128'(error), 128'(m_error));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(m_load || m_pending));
    modelStep(1'b0, 32'h0, rdy);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1; inst_part_en = 1'b0; inst_part = '0; cnn_inst_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_load = 0; m_pending = 0; m_error = 0; m_count = 0; m_rem = 0; m_silent = 0;
    m_part.delete();
    checkOutput("rst_wren", 128'(ram_wren), 128'(0));
    checkOutput("rst_wraddr", 128'(ram_wraddr), 128'(0));
    checkOutput("rst_data", ram_data, 128'(0));
    checkOutput("rst_start", 128'(cnn_inst_start), 128'(0));
    checkOutput("rst_count", 128'(inst_count), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_error", 128'(error), 128'(0));
  endtask

  // Monitor: every write and start pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    wr_t e;
    while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
      e = exp_wr.pop_front();
      checkOutput("wr_missed_cycle", 128'(cyc), 128'(e.cyc));
    end
    while (exp_start.size() > 0 && exp_start[0] < cyc) begin
      checkOutput("start_missed_cycle", 128'(cyc), 128'(exp_start.pop_front()));
    end
    if (ram_wren) begin
      if (exp_wr.size() == 0) checkOutput("unexpected_write", 128'(ram_wren), 128'(0));
      else begin
        e = exp_wr.pop_front();
        checkOutput("wr_cycle", 128'(cyc), 128'(e.cyc));
        checkOutput("wr_addr", 128'(ram_wraddr), 128'(e.addr));
        checkOutput("wr_data", ram_data, e.data);
      end
    end
    if (cnn_inst_start) begin
      pulses_seen++;
      if (exp_start.size() == 0) checkOutput("unexpected_start", 128'(cnn_inst_start), 128'(0));
      else checkOutput("start_cycle", 128'(cyc), 128'(exp_start.pop_front()));
    end
  end

  initial begin
    int n;
    logic rdy;
    logic [31:0] w;
    rst = 1'b1; inst_part_en = 1'b0; inst_part = '0; cnn_inst_ready = 1'b0;
    doReset();

    // Two-instruction load with an incrementing word pattern.
    applyStimulus(1, 32'h1, 0);
    applyStimulus(1, 32'hA5A5_0002, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 32'(i), 0);
    idleAndCheck(0, "load2");

    // START held off by a busy executor; the second START merges.
    applyStimulus(1, 32'h2, 0);
    repeat (4) applyStimulus(0, 0, 0);
    applyStimulus(1, 32'h2, 0);
    repeat (5) applyStimulus(0, 0, 0);
    idleAndCheck(1, "start_pend");
    repeat (4) applyStimulus(0, 0, 1);
    idleAndCheck(1, "start_done");

    // Command and magic values inside a frame are plain data.
    applyStimulus(1, 32'hA5A5_0001, 1);
    applyStimulus(1, 32'h1, 1);
    applyStimulus(1, 32'h2, 1);
    applyStimulus(1, 32'hA5A5_0001, 1);
    applyStimulus(1, 32'h2, 1);
    idleAndCheck(1, "magic_data");

    // Five instructions into a four-entry RAM.
    applyStimulus(1, 32'h1, 0);
    applyStimulus(1, 32'hA5A5_0005, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, $urandom, 0);
    idleAndCheck(0, "overflow");

    // Stalled frame times out, then CLEAR drops the error.
    applyStimulus(1, 32'h1, 0);
    applyStimulus(1, 32'hA5A5_0001, 0);
    applyStimulus(1, 32'hDEAD_0000, 0);
    applyStimulus(1, 32'hDEAD_0001, 0);
    repeat (TIMEOUT + 4) applyStimulus(0, 0, 0);
    idleAndCheck(0, "timeout");
    applyStimulus(1, 32'h1, 0);
    idleAndCheck(0, "clear_err");

    // Reset in the middle of an instruction, then a garbage word in IDLE.
    applyStimulus(1, 32'hA5A5_0001, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h100 + 32'(i), 0);
    doReset();
    applyStimulus(1, 32'h1234_5678, 0);
    idleAndCheck(0, "garbage");

    // Zero-length LOAD header.
    applyStimulus(1, 32'h1, 0);
    applyStimulus(1, 32'hA5A5_0000, 0);
    idleAndCheck(0, "n_zero");

    // Random command mix, payloads, gaps and executor readiness.
    applyStimulus(1, 32'h1, 0);
    for (int f = 0; f < 40; f++) begin
      rdy = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       applyStimulus(1, 32'h1, rdy);
        1, 2:    applyStimulus(1, 32'h2, rdy);
        3:       applyStimulus(1, {16'h1234, 16'($urandom)}, rdy);
        default: begin
          n = $urandom_range(1, 3);
          applyStimulus(1, {16'hA5A5, 16'(n)}, rdy);
          for (int k = 0; k < 4 * n; k++) begin
            if ($urandom_range(0, 15) == 0)
              repeat ($urandom_range(1, TIMEOUT + 3)) applyStimulus(0, 0, 1'($urandom_range(0, 1)));
            w = ($urandom_range(0, 7) == 0) ? {16'hA5A5, 16'($urandom_range(0, 3))} : $urandom;
            applyStimulus(1, w, 1'($urandom_range(0, 1)));
          end
        end
      endcase
      idleAndCheck(1'($urandom_range(0, 1)), "rand");
    end

    repeat (3) applyStimulus(0, 0, 1);
    idleAndCheck(1, "final");
    repeat (2) @(posedge clk);
    checkOutput("wr_queue_drained", 128'(exp_wr.size()), 128'(0));
    checkOutput("start_queue_drained", 128'(exp_start.size()), 128'(0));
    checkOutput("start_pulse_total", 128'(pulses_seen), 128'(pulses_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
